ika87ad_opfetch: RTL and testbench

Opcode fetch and prefix sequencer for the IKA87AD core. Reads opcode bytes from the bus, folds the five prefix bytes into a 3-bit opcode page, and presents opcode plus page to the opcode decoder with a one-cycle dispatch strobe. At each instruction boundary it can inject the HARDI opcode in place of a bus fetch. It sits between the bus interface unit and the opcode decoder / microcode sequencer.

---
 rtl/ika87ad_opfetch_if.sv | 36 +++
 rtl/ika87ad_opfetch.sv | 158 +++++++++++++++
 tb/tb_ika87ad_opfetch.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ika87ad_opfetch_if.sv
// ============================================================================
// Module   : ika87ad_opfetch_if
// Brief    : Fetch/decode handshake bundle between the IKA87AD opcode fetch
//            unit, the bus interface unit and the decoder/microsequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ika87ad_opfetch_if;
    logic       i_NEXT;
    logic       o_BUS_RD;
    logic       i_BUS_ACK;
    logic [7:0] i_BUS_DATA;
    logic       o_PC_INC;
    logic       o_M1;
    logic       i_INT_PEND;
    logic       i_INT_INHIBIT;
    logic       o_INT_ACK;
    logic [7:0] o_OPCODE;
    logic [2:0] o_OPCODE_PAGE;
    logic       o_DISPATCH;

    // master: the opcode fetch unit itself
    modport master (
        input  i_NEXT, i_BUS_ACK, i_BUS_DATA, i_INT_PEND, i_INT_INHIBIT,
        output o_BUS_RD, o_PC_INC, o_M1, o_INT_ACK, o_OPCODE, o_OPCODE_PAGE, o_DISPATCH
    );

    // slave: the surrounding bus unit / decoder / sequencer
    modport slave (
        output i_NEXT, i_BUS_ACK, i_BUS_DATA, i_INT_PEND, i_INT_INHIBIT,
        input  o_BUS_RD, o_PC_INC, o_M1, o_INT_ACK, o_OPCODE, o_OPCODE_PAGE, o_DISPATCH
    );
endinterface

`default_nettype wire

// File: rtl/ika87ad_opfetch.sv
// ============================================================================
// Module   : ika87ad_opfetch
// Brief    : Opcode fetch and prefix sequencer; folds prefix bytes into a
//            3-bit opcode page and injects HARDI at instruction boundaries
//            when built with IKA87AD_HARDI_INJECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ika87ad_opfetch #(
    parameter logic [7:0] HARDI_OPCODE = 8'h73
) (
    input  wire logic           i_CLK,
    input  wire logic           i_RST,
    ika87ad_opfetch_if.master   fetch
);

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_OP1   = 3'd1,
        ST_OP2   = 3'd2,
        ST_DISP  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [2:0] page_q, page_d;
    logic [2:0] pfx_page_q, pfx_page_d;

    logic       w_bus_rd;
    logic       w_m1;
    logic       w_dispatch;
    logic       w_boundary;
    logic       w_inject;
    logic       w_pfx_hit;
    logic [2:0] w_pfx_page;

    always_comb begin
        w_pfx_hit  = 1'b1;
        w_pfx_page = 3'd0;
        case (fetch.i_BUS_DATA)
            8'h48:   w_pfx_page = 3'd1;
            8'h60:   w_pfx_page = 3'd2;
            8'h64:   w_pfx_page = 3'd3;
            8'h70:   w_pfx_page = 3'd4;
            8'h74:   w_pfx_page = 3'd5;
            default: w_pfx_hit  = 1'b0;
        endcase
    end

`ifdef IKA87AD_HARDI_INJECT_EN
    assign w_inject = fetch.i_INT_PEND & ~fetch.i_INT_INHIBIT;
`else
    logic w_unused_int;
    assign w_unused_int = fetch.i_INT_PEND ^ fetch.i_INT_INHIBIT;
    assign w_inject     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        page_d     = page_q;
        pfx_page_d = pfx_page_q;
        w_bus_rd   = 1'b0;
        w_m1       = 1'b0;
        w_dispatch = 1'b0;
        w_boundary = 1'b0;

        case (state_q)
            ST_RESET: state_d = ST_OP1;
            ST_OP1: begin
                w_bus_rd = 1'b1;
                w_m1     = 1'b1;
                if (fetch.i_BUS_ACK) begin
                    if (w_pfx_hit) begin
                        pfx_page_d = w_pfx_page;
                        state_d    = ST_OP2;
                    end else begin
                        opcode_d = fetch.i_BUS_DATA;
                        page_d   = 3'd0;
                        state_d  = ST_DISP;
                    end
                end
            end
            ST_OP2: begin
                // Second byte is always the opcode, even if it looks like a prefix
                w_bus_rd = 1'b1;
                if (fetch.i_BUS_ACK) begin
                    opcode_d = fetch.i_BUS_DATA;
                    page_d   = pfx_page_q;
                    state_d  = ST_DISP;
                end
            end
            ST_DISP: begin
                w_dispatch = 1'b1;
                if (fetch.i_NEXT) w_boundary = 1'b1;
                else              state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (fetch.i_NEXT) w_boundary = 1'b1;
            end
            default: state_d = ST_RESET;
        endcase

        if (w_boundary) begin
            if (w_inject) begin
                opcode_d = HARDI_OPCODE;
                page_d   = 3'd0;
                state_d  = ST_DISP;
            end else begin
                state_d  = ST_OP1;
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q    <= ST_RESET;
            opcode_q   <= 8'h00;
            page_q     <= 3'd0;
            pfx_page_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            page_q     <= page_d;
            pfx_page_q <= pfx_page_d;
        end
    end

`ifdef IKA87AD_HARDI_INJECT_EN
    logic int_ack_q, int_ack_d;

    always_comb begin
        int_ack_d = w_boundary & w_inject;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) int_ack_q <= 1'b0;
        else       int_ack_q <= int_ack_d;
    end

    assign fetch.o_INT_ACK = int_ack_q & ~i_RST;
`else
    assign fetch.o_INT_ACK = 1'b0;
`endif

    // Reset masks all strobes so a byte acked during reset leaves no trace
    assign fetch.o_BUS_RD      = w_bus_rd & ~i_RST;
    assign fetch.o_M1          = w_m1 & ~i_RST;
    assign fetch.o_PC_INC      = w_bus_rd & fetch.i_BUS_ACK & ~i_RST;
    assign fetch.o_DISPATCH    = w_dispatch & ~i_RST;
    assign fetch.o_OPCODE      = opcode_q;
    assign fetch.o_OPCODE_PAGE = page_q;

endmodule

`default_nettype wire

// File: tb/tb_ika87ad_opfetch.sv
// ============================================================================
// Module   : tb_ika87ad_opfetch
// Brief    : Directed self-checking bench for ika87ad_opfetch with a
//            transaction-level reference model and literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ika87ad_opfetch;

`ifdef IKA87AD_HARDI_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    ika87ad_opfetch_if u_if ();

    ika87ad_opfetch #(.HARDI_OPCODE(8'h73)) u_dut (
        .i_CLK (clk),
        .i_RST (rst),
        .fetch (u_if)
    );

    always #5 clk = ~clk;

    // Reference model: tracks where the instruction is, not how the RTL encodes it
    bit       m_started  = 1'b0;
    bit       m_fetching = 1'b0;
    int       m_nbytes   = 0;
    bit       m_disp     = 1'b0;
    bit       m_intack   = 1'b0;
    bit [7:0] m_op       = 8'h00;
    bit [2:0] m_page     = 3'd0;
    bit [2:0] m_pfx      = 3'd0;

    function automatic int pfx_page(input bit [7:0] b);
        case (b)
            8'h48: return 1;
            8'h60: return 2;
            8'h64: return 3;
            8'h70: return 4;
            8'h74: return 5;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_started = 0; m_fetching = 0; m_disp = 0; m_intack = 0;
            m_op = 8'h00; m_page = 3'd0; m_nbytes = 0;
        end else if (!m_started) begin
            m_started = 1; m_fetching = 1; m_nbytes = 0;
        end else if (m_fetching) begin
            if (u_if.i_BUS_ACK) begin
                if (m_nbytes == 0 && pfx_page(u_if.i_BUS_DATA) != 0) begin
                    m_nbytes = 1;
                    m_pfx    = 3'(pfx_page(u_if.i_BUS_DATA));
                end else begin
                    m_op       = u_if.i_BUS_DATA;
                    m_page     = (m_nbytes == 1) ? m_pfx : 3'd0;
                    m_fetching = 0;
                    m_disp     = 1;
                end
            end
        end else begin
            m_intack = 0;
            if (u_if.i_NEXT) begin
                if (INJ && u_if.i_INT_PEND && !u_if.i_INT_INHIBIT) begin
                    m_op = 8'h73; m_page = 3'd0; m_disp = 1; m_intack = 1;
                end else begin
                    m_disp = 0; m_fetching = 1; m_nbytes = 0;
                end
            end else begin
                m_disp = 0;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic       e_rd, e_m1, e_inc, e_disp, e_ack;
        e_rd   = !rst && m_fetching;
        e_m1   = e_rd && (m_nbytes == 0);
        e_inc  = e_rd && u_if.i_BUS_ACK;
        e_disp = !rst && m_disp;
        e_ack  = !rst && m_intack;
        n_vec++;
        if (u_if.o_BUS_RD !== e_rd || u_if.o_M1 !== e_m1 || u_if.o_PC_INC !== e_inc ||
            u_if.o_DISPATCH !== e_disp || u_if.o_INT_ACK !== e_ack ||
            u_if.o_OPCODE !== m_op || u_if.o_OPCODE_PAGE !== m_page) begin
            n_bad++;
            $display("FAIL model t=%0t got rd=%b m1=%b inc=%b disp=%b ack=%b op=%h pg=%0d expected rd=%b m1=%b inc=%b disp=%b ack=%b op=%h pg=%0d",
                     $time, u_if.o_BUS_RD, u_if.o_M1, u_if.o_PC_INC, u_if.o_DISPATCH,
                     u_if.o_INT_ACK, u_if.o_OPCODE, u_if.o_OPCODE_PAGE,
                     e_rd, e_m1, e_inc, e_disp, e_ack, m_op, m_page);
        end
    end

    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit nx, input bit ack, input bit [7:0] d,
                         input bit pend, input bit inh);
        u_if.i_NEXT = nx; u_if.i_BUS_ACK = ack; u_if.i_BUS_DATA = d;
        u_if.i_INT_PEND = pend; u_if.i_INT_INHIBIT = inh;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 8'h00, 0, 0);
        repeat (3) tick();
        lit("rst_rd",   8'(u_if.o_BUS_RD), 8'h0);
        lit("rst_op",   u_if.o_OPCODE, 8'h00);
        lit("rst_disp", 8'(u_if.o_DISPATCH), 8'h0);

        // Plain fetch with two wait states
        rst = 0; tick();
        drive(0, 0, 8'h00, 0, 0); tick();
        drive(0, 0, 8'h00, 0, 0); tick();
        drive(0, 1, 8'h54, 0, 0);
        lit("s1_inc", 8'(u_if.o_PC_INC), 8'h1);
        tick();
        drive(1, 0, 8'h00, 0, 0);
        lit("s1_disp", 8'(u_if.o_DISPATCH), 8'h1);
        lit("s1_op", u_if.o_OPCODE, 8'h54);
        lit("s1_pg", 8'(u_if.o_OPCODE_PAGE), 8'h0);
        tick();

        // Prefix 74 then 88
        drive(0, 1, 8'h74, 0, 0);
        lit("s2_m1a", 8'(u_if.o_M1), 8'h1);
        tick();
        drive(0, 1, 8'h88, 0, 0);
        lit("s2_m1b", 8'(u_if.o_M1), 8'h0);
        lit("s2_inc", 8'(u_if.o_PC_INC), 8'h1);
        tick();
        drive(0, 0, 8'h00, 0, 0);
        lit("s2_op", u_if.o_OPCODE, 8'h88);
        lit("s2_pg", 8'(u_if.o_OPCODE_PAGE), 8'h5);
        tick();
        drive(1, 0, 8'h00, 0, 0); tick();

        // Prefix value as second byte: no chaining
        drive(0, 1, 8'h48, 0, 0); tick();
        drive(0, 1, 8'h48, 0, 0); tick();
        lit("s3_op", u_if.o_OPCODE, 8'h48);
        lit("s3_pg", 8'(u_if.o_OPCODE_PAGE), 8'h1);
        drive(1, 0, 8'h00, 0, 0); tick();
        drive(0, 1, 8'h12, 0, 0);
        lit("s3_m1", 8'(u_if.o_M1), 8'h1);
        tick();
        lit("s3_pg0", 8'(u_if.o_OPCODE_PAGE), 8'h0);
        drive(0, 0, 8'h00, 0, 0); tick();

        // Interrupt at a WAIT boundary, then inhibited
        drive(1, 0, 8'h00, 1, 0); tick();
        lit("s4_ack", 8'(u_if.o_INT_ACK), 8'(INJ));
        lit("s4_rd",  8'(u_if.o_BUS_RD), 8'(!INJ));
        lit("s4_op",  u_if.o_OPCODE, INJ ? 8'h73 : 8'h12);
        drive(0, 1, 8'h00, 0, 0); tick();
        drive(0, 0, 8'h00, 0, 0); tick();
        drive(1, 0, 8'h00, 1, 1); tick();
        lit("s4_inh_rd",  8'(u_if.o_BUS_RD), 8'h1);
        lit("s4_inh_ack", 8'(u_if.o_INT_ACK), 8'h0);

        // Interrupt raised during OP2 must not split the prefix pair
        drive(0, 1, 8'h60, 0, 0); tick();
        drive(1, 1, 8'hC1, 1, 0); tick();
        lit("s5_op",  u_if.o_OPCODE, 8'hC1);
        lit("s5_pg",  8'(u_if.o_OPCODE_PAGE), 8'h2);
        lit("s5_ack", 8'(u_if.o_INT_ACK), 8'h0);
        tick();
        lit("s5_hardi", 8'(u_if.o_INT_ACK), 8'(INJ));
        drive(1, 0, 8'h00, 0, 0); tick();

        // Reset in the OP2 ack cycle
        drive(0, 1, 8'h64, 0, 0); tick();
        drive(0, 1, 8'h99, 0, 0);
        rst = 1; #1;
        lit("s6_inc",  8'(u_if.o_PC_INC), 8'h0);
        lit("s6_disp", 8'(u_if.o_DISPATCH), 8'h0);
        tick();
        rst = 0;
        drive(0, 0, 8'h00, 0, 0); tick();
        lit("s6_m1", 8'(u_if.o_M1), 8'h1);
        lit("s6_op", u_if.o_OPCODE, 8'h00);
        drive(0, 1, 8'h55, 0, 0); tick();
        lit("s6_pg", 8'(u_if.o_OPCODE_PAGE), 8'h0);
        lit("s6_op2", u_if.o_OPCODE, 8'h55);
        drive(1, 0, 8'h00, 0, 0); tick();
        drive(0, 0, 8'h00, 0, 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
